// File: rtl/main_fsm.sv
// Multicycle RV32I main control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath selects, aluOp and write enables. Optional trap state: MAIN_FSM_ILLEGAL_TRAP_EN.
module main_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] aluOp,
    output logic       reg_write,
    output logic       illegal
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
        S_TRAP     = 4'd11,
`endif
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    state_t state_q, state_d;

    logic pc_update, branch;
    logic ir_write_c, mem_write_c, reg_write_c;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = S_FETCH;
        pc_update   = 1'b0;
        branch      = 1'b0;
        ir_write_c  = 1'b0;
        mem_write_c = 1'b0;
        reg_write_c = 1'b0;
        adr_src     = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        aluOp       = 2'b00;
        illegal     = 1'b0;
        case (state_q)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_update  = 1'b1;
                    state_d    = S_DECODE;
                end else begin
                    state_d    = S_FETCH;
                end
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut while the opcode is decoded.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXEC_R;
                    OP_ITYPE:          state_d = S_EXEC_I;
                    OP_JAL:            state_d = S_JAL;
                    OP_BRANCH:         state_d = S_BEQ;
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
                    default:           state_d = S_TRAP;
`else
                    default:           state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                result_src  = 2'b01;
                reg_write_c = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src     = 1'b1;
                mem_write_c = 1'b1;
                state_d     = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXEC_R: begin
                alu_src_a = 2'b10;
                aluOp     = 2'b10;
                state_d   = S_ALUWB;
            end
            S_EXEC_I: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                aluOp     = 2'b10;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                aluOp     = 2'b01;
                branch    = 1'b1;
            end
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
            S_TRAP: begin
                illegal = 1'b1;
                state_d = S_TRAP;
            end
`endif
            default: state_d = S_FETCH;
        endcase
    end

    // Write enables are suppressed combinationally for the whole reset cycle.
    assign pc_write  = ~reset & (pc_update | (branch & zero));
    assign ir_write  = ~reset & ir_write_c;
    assign mem_write = ~reset & mem_write_c;
    assign reg_write = ~reset & reg_write_c;

endmodule

// File: tb/tb_main_fsm.sv
// Directed self-checking bench for main_fsm; expectations follow MAIN_FSM_ILLEGAL_TRAP_EN.
module tb_main_fsm;

    logic       clk = 1'b0;
    logic       reset, zero, mem_ready;
    logic [6:0] op;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b, aluOp;
    logic [13:0] outs;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    main_fsm dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .aluOp(aluOp), .reg_write(reg_write), .illegal(illegal)
    );

    // {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b, aluOp, reg_write, illegal}
    assign outs = {pc_write, adr_src, mem_write, ir_write, result_src,
                   alu_src_a, alu_src_b, aluOp, reg_write, illegal};

    localparam logic [13:0] X_FETCH    = 14'b1_0_0_1_10_00_10_00_0_0;
    localparam logic [13:0] X_FETCH_ST = 14'b0_0_0_0_10_00_10_00_0_0;
    localparam logic [13:0] X_DECODE   = 14'b0_0_0_0_00_01_01_00_0_0;
    localparam logic [13:0] X_MEMADR   = 14'b0_0_0_0_00_10_01_00_0_0;
    localparam logic [13:0] X_MEMREAD  = 14'b0_1_0_0_00_00_00_00_0_0;
    localparam logic [13:0] X_MEMWB    = 14'b0_0_0_0_01_00_00_00_1_0;
    localparam logic [13:0] X_MEMWRITE = 14'b0_1_1_0_00_00_00_00_0_0;
    localparam logic [13:0] X_EXEC_R   = 14'b0_0_0_0_00_10_00_10_0_0;
    localparam logic [13:0] X_EXEC_I   = 14'b0_0_0_0_00_10_01_10_0_0;
    localparam logic [13:0] X_ALUWB    = 14'b0_0_0_0_00_00_00_00_1_0;
    localparam logic [13:0] X_JAL      = 14'b1_0_0_0_00_01_10_00_0_0;
    localparam logic [13:0] X_BEQ_T    = 14'b1_0_0_0_00_10_00_01_0_0;
    localparam logic [13:0] X_BEQ_N    = 14'b0_0_0_0_00_10_00_01_0_0;
    localparam logic [13:0] X_ZERO     = 14'b0;
    localparam logic [13:0] X_TRAP     = 14'b0_0_0_0_00_00_00_00_0_1;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, JL = 7'b1101111, BQ = 7'b1100011;
    localparam logic [6:0] BAD = 7'b1111111;

    task automatic check(input string tag, input logic [13:0] got, input logic [13:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    // Drive one cycle's inputs, check outputs mid-cycle, then advance one clock.
    task automatic cyc(input string tag, input logic [6:0] o, input logic mr,
                       input logic z, input logic rst, input logic [13:0] exp);
        op = o; mem_ready = mr; zero = z; reset = rst;
        #1;
        check(tag, outs, exp);
        @(negedge clk);
    endtask

    initial begin
        op = RT; mem_ready = 1'b1; zero = 1'b0; reset = 1'b1;
        @(negedge clk);
        // First reset cycle: state undefined, but every write enable is gated off.
        #1;
        check("rst0_en", {10'b0, pc_write, ir_write, mem_write, reg_write}, 14'b0);
        @(negedge clk);
        cyc("rst1", RT, 1'b1, 1'b0, 1'b1, X_FETCH_ST);

        // R-type
        cyc("r_fetch",  RT, 1'b1, 1'b0, 1'b0, X_FETCH);
        cyc("r_decode", RT, 1'b1, 1'b0, 1'b0, X_DECODE);
        cyc("r_exec",   RT, 1'b1, 1'b0, 1'b0, X_EXEC_R);
        cyc("r_wb",     RT, 1'b1, 1'b0, 1'b0, X_ALUWB);

        // lw, with one MEMREAD stall and op wiggled outside DECODE/MEMADR
        cyc("lw_fetch",  BAD, 1'b1, 1'b0, 1'b0, X_FETCH);
        cyc("lw_decode", LW,  1'b1, 1'b0, 1'b0, X_DECODE);
        cyc("lw_memadr", LW,  1'b1, 1'b0, 1'b0, X_MEMADR);
        cyc("lw_mrd_st", RT,  1'b0, 1'b0, 1'b0, X_MEMREAD);
        cyc("lw_mrd",    SW,  1'b1, 1'b0, 1'b0, X_MEMREAD);
        cyc("lw_wb",     BQ,  1'b1, 1'b0, 1'b0, X_MEMWB);

        // sw with three stall cycles in MEMWRITE
        cyc("sw_fetch",  SW, 1'b1, 1'b0, 1'b0, X_FETCH);
        cyc("sw_decode", SW, 1'b1, 1'b0, 1'b0, X_DECODE);
        cyc("sw_memadr", SW, 1'b1, 1'b0, 1'b0, X_MEMADR);
        cyc("sw_mw0",    SW, 1'b0, 1'b0, 1'b0, X_MEMWRITE);
        cyc("sw_mw1",    SW, 1'b0, 1'b0, 1'b0, X_MEMWRITE);
        cyc("sw_mw2",    SW, 1'b0, 1'b0, 1'b0, X_MEMWRITE);
        cyc("sw_mw3",    SW, 1'b1, 1'b0, 1'b0, X_MEMWRITE);

        // beq taken
        cyc("bt_fetch",  BQ, 1'b1, 1'b1, 1'b0, X_FETCH);
        cyc("bt_decode", BQ, 1'b1, 1'b1, 1'b0, X_DECODE);
        cyc("bt_beq",    BQ, 1'b1, 1'b1, 1'b0, X_BEQ_T);
        // beq not taken
        cyc("bn_fetch",  BQ, 1'b1, 1'b0, 1'b0, X_FETCH);
        cyc("bn_decode", BQ, 1'b1, 1'b0, 1'b0, X_DECODE);
        cyc("bn_beq",    BQ, 1'b1, 1'b0, 1'b0, X_BEQ_N);

        // fetch stall then jal
        cyc("j_fst0",   JL, 1'b0, 1'b0, 1'b0, X_FETCH_ST);
        cyc("j_fst1",   JL, 1'b0, 1'b0, 1'b0, X_FETCH_ST);
        cyc("j_fetch",  JL, 1'b1, 1'b0, 1'b0, X_FETCH);
        cyc("j_decode", JL, 1'b1, 1'b0, 1'b0, X_DECODE);
        cyc("j_jal",    JL, 1'b1, 1'b0, 1'b0, X_JAL);
        cyc("j_wb",     JL, 1'b1, 1'b0, 1'b0, X_ALUWB);

        // I-type, reset asserted in ALUWB
        cyc("i_fetch",  IT, 1'b1, 1'b0, 1'b0, X_FETCH);
        cyc("i_decode", IT, 1'b1, 1'b0, 1'b0, X_DECODE);
        cyc("i_exec",   IT, 1'b1, 1'b0, 1'b0, X_EXEC_I);
        cyc("i_wb_rst", IT, 1'b1, 1'b0, 1'b1, X_ZERO);
        cyc("i_refetch", IT, 1'b1, 1'b0, 1'b0, X_FETCH);
        cyc("i_decode2", IT, 1'b1, 1'b0, 1'b0, X_DECODE);
        cyc("i_exec2",   IT, 1'b1, 1'b0, 1'b0, X_EXEC_I);
        cyc("i_wb2",     IT, 1'b1, 1'b0, 1'b0, X_ALUWB);

        // illegal opcode
        cyc("il_fetch",  BAD, 1'b1, 1'b0, 1'b0, X_FETCH);
        cyc("il_decode", BAD, 1'b1, 1'b0, 1'b0, X_DECODE);
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
        for (int i = 0; i < 10; i++) cyc("il_trap", RT, 1'b1, 1'b1, 1'b0, X_TRAP);
        op = RT; mem_ready = 1'b1; zero = 1'b0; reset = 1'b1;
        #1;
        check("il_rst_en", {10'b0, pc_write, ir_write, mem_write, reg_write}, 14'b0);
        @(negedge clk);
        cyc("il_after", RT, 1'b1, 1'b0, 1'b0, X_FETCH);
`else
        cyc("il_nop", RT, 1'b1, 1'b0, 1'b0, X_FETCH);
        cyc("il_next", RT, 1'b1, 1'b0, 1'b0, X_DECODE);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
